sr_flip_flop: RTL and testbench



---
 rtl/sr_pkg.sv | 29 ++
 rtl/sr_cell.sv | 34 +++
 rtl/sr_flip_flop.sv | 46 ++++
 tb/tb_sr_flip_flop.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// sr_pkg
// Shared definitions for the SR flip-flop slice:
//   sr_cmd_t  - 2-bit command {s, r}
//   SR_*      - named command encodings
//   next_q    - next-state function for one slice, usable by any model
package sr_pkg;

  typedef logic [1:0] sr_cmd_t;

  localparam sr_cmd_t SR_HOLD = 2'b00;
  localparam sr_cmd_t SR_CLR  = 2'b01;
  localparam sr_cmd_t SR_SET  = 2'b10;
  localparam sr_cmd_t SR_BAD  = 2'b11;

  // Next state of one slice. The forbidden {1,1} command is defined as
  // hold so the stored bit never goes X or oscillates.
  function automatic logic next_q(input sr_cmd_t cmd, input logic q);
    logic nq;
    case (cmd)
      SR_HOLD: nq = q;
      SR_CLR:  nq = 1'b0;
      SR_SET:  nq = 1'b1;
      SR_BAD:  nq = q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// sr_cell
// Single SR storage bit with asynchronous active-low clear to RESET_VAL.
// Ports:
//   clk   in  1  rising-edge clock
//   reset in  1  asynchronous active-low reset (0 = in reset)
//   s     in  1  set command
//   r     in  1  clear command
//   q     out 1  stored bit (registered)
module sr_cell
  import sr_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q
);

  sr_cmd_t cmd_s;

  assign cmd_s = {s, r};

  // State register: reset has priority over any coincident clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else begin
      q <= next_q(cmd_s, q);
    end
  end

endmodule

// File: rtl/sr_flip_flop.sv
// sr_flip_flop
// Vector of WIDTH independent clocked SR flip-flops with asynchronous
// active-low clear.
// Parameters:
//   WIDTH     number of slices
//   RESET_VAL value held in q while reset is low
// Ports:
//   clk   in  1      rising-edge clock
//   reset in  1      asynchronous active-low reset (0 = in reset)
//   s     in  WIDTH  per-slice set command
//   r     in  WIDTH  per-slice clear command
//   q     out WIDTH  stored state (registered)
//   q_bar out WIDTH  complement of q, taken from the same register
module sr_flip_flop
  import sr_pkg::*;
#(
  parameter int                WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      sr_cell #(
        .RESET_VAL (RESET_VAL[i])
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .s     (s[i]),
        .r     (r[i]),
        .q     (q[i])
      );
    end
  endgenerate

  // Derived from q rather than a second flop so the two can never disagree.
  assign q_bar = ~q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// tb_sr_flip_flop
// Directed test of sr_flip_flop with a 1-bit instance (RESET_VAL=0) and a
// 4-bit instance (RESET_VAL=4'b1010). Stimulus pushes hand-computed
// expectations into a queue; a monitor process pops and compares them.
module tb_sr_flip_flop;

  logic       clk;
  logic       reset_a;
  logic [0:0] s_a;
  logic [0:0] r_a;
  logic [0:0] q_a;
  logic [0:0] qb_a;

  logic       reset_b;
  logic [3:0] s_b;
  logic [3:0] r_b;
  logic [3:0] q_b;
  logic [3:0] qb_b;

  sr_flip_flop #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_dut_a (
    .clk   (clk),
    .reset (reset_a),
    .s     (s_a),
    .r     (r_a),
    .q     (q_a),
    .q_bar (qb_a)
  );

  sr_flip_flop #(
    .WIDTH     (4),
    .RESET_VAL (4'b1010)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset_b),
    .s     (s_b),
    .r     (r_b),
    .q     (q_b),
    .q_bar (qb_b)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         dut;
    logic [3:0] q;
    logic [3:0] qb;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   total;
  int   bad;

  // Monitor: drains every pending expectation when the stimulus signals
  // that the outputs are ready to be observed.
  initial begin
    total = 0;
    bad   = 0;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [3:0] aq;
        logic [3:0] aqb;
        e = exp_q.pop_front();
        if (e.dut == 0) begin
          aq  = {3'b000, q_a};
          aqb = {3'b000, qb_a};
        end else begin
          aq  = q_b;
          aqb = qb_b;
        end
        total++;
        if (aq !== e.q || aqb !== e.qb) begin
          bad++;
          $display("FAIL %s: got q=%b q_bar=%b, expected q=%b q_bar=%b",
                   e.name, aq, aqb, e.q, e.qb);
        end
      end
    end
  end

  task automatic expect_a(input logic qv, input string name);
    exp_t e;
    e.dut  = 0;
    e.q    = {3'b000, qv};
    e.qb   = {3'b000, ~qv};
    e.name = name;
    exp_q.push_back(e);
    -> chk_ev;
    #0;
  endtask

  task automatic expect_b(input logic [3:0] qv, input string name);
    exp_t e;
    e.dut  = 1;
    e.q    = qv;
    e.qb   = ~qv;
    e.name = name;
    exp_q.push_back(e);
    -> chk_ev;
    #0;
  endtask

  // Advance to one unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    s_a = 1'b0;
    r_a = 1'b0;
    s_b = 4'b0000;
    r_b = 4'b0000;

    // 1. Reset takes effect before any clock edge and ignores s.
    #2;
    reset_a = 1'b0;
    reset_b = 1'b0;
    #1;
    expect_a(1'b0, "reset_immediate");
    expect_b(4'b1010, "reset_immediate_w4");
    s_a = 1'b1;
    s_b = 4'b0101;
    r_b = 4'b1000;
    tick();
    expect_a(1'b0, "reset_hold_edge1");
    tick();
    expect_a(1'b0, "reset_hold_edge2");
    expect_b(4'b1010, "reset_hold_w4");

    // 2. Set then clear.
    #3;
    reset_a = 1'b1;
    s_a = 1'b1;
    r_a = 1'b0;
    tick();
    expect_a(1'b1, "set");
    s_a = 1'b0;
    r_a = 1'b1;
    tick();
    expect_a(1'b0, "clear");

    // 3. Forbidden combination holds from either state.
    s_a = 1'b1;
    r_a = 1'b0;
    tick();
    expect_a(1'b1, "set_before_bad");
    s_a = 1'b1;
    r_a = 1'b1;
    tick();
    expect_a(1'b1, "bad_holds_1");
    s_a = 1'b0;
    r_a = 1'b1;
    tick();
    expect_a(1'b0, "clear_before_bad");
    s_a = 1'b1;
    r_a = 1'b1;
    tick();
    expect_a(1'b0, "bad_holds_0");

    // 4. Hold for five edges, then glitch s/r between edges.
    s_a = 1'b1;
    r_a = 1'b0;
    tick();
    expect_a(1'b1, "set_before_hold");
    s_a = 1'b0;
    r_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_a(1'b1, $sformatf("hold_edge%0d", k));
    end
    #1;
    s_a = 1'b0;
    r_a = 1'b1;
    #2;
    s_a = 1'b1;
    r_a = 1'b1;
    #2;
    s_a = 1'b0;
    r_a = 1'b1;
    #1;
    s_a = 1'b0;
    r_a = 1'b0;
    #1;
    expect_a(1'b1, "glitch_no_edge");
    tick();
    expect_a(1'b1, "glitch_after_edge");

    // 5. Mid-cycle reset, reset winning over a coincident edge, release.
    #2;
    reset_a = 1'b0;
    #1;
    expect_a(1'b0, "midcycle_reset");
    s_a = 1'b1;
    r_a = 1'b0;
    tick();
    expect_a(1'b0, "reset_priority_edge");
    #3;
    reset_a = 1'b1;
    #1;
    expect_a(1'b0, "release_before_edge");
    tick();
    expect_a(1'b1, "release_then_set");

    // 6. 4-bit instance: per-slice independence.
    #3;
    reset_b = 1'b1;
    s_b = 4'b0101;
    r_b = 4'b1000;
    tick();
    expect_b(4'b0111, "w4_mixed");
    s_b = 4'b1111;
    r_b = 4'b1111;
    tick();
    expect_b(4'b0111, "w4_bad_holds");
    s_b = 4'b0000;
    r_b = 4'b0111;
    tick();
    expect_b(4'b0000, "w4_clear_low3");
    s_b = 4'b1001;
    r_b = 4'b0000;
    tick();
    expect_b(4'b1001, "w4_set_ends");

    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
